// File: rtl/unidade_controle.sv
// unidade_controle: multi-cycle control unit for a small RISC-V-like core.
// Sequences FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> PCUPD, with a bounded wait
// for mem_ready in FETCH/MEM and a terminal HALT state left only through reset.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   opcode, funct3    instruction fields from the external instruction register
//   zero              ALU zero flag, sampled in EXEC
//   mem_ready         memory completion, honoured only in FETCH and MEM
//   estado            registered state code
//   pcsrc             branch target select, meaningful in PCUPD
//   ir_load .. aluop  datapath strobes
//   halted            high in HALT
//   err_timeout       sticky memory-timeout flag
//   instret           retired-instruction count
module unidade_controle #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        zero,
    input  logic        mem_ready,
    output logic [2:0]  estado,
    output logic        pcsrc,
    output logic        ir_load,
    output logic        memread,
    output logic        memwrite,
    output logic        regwrite,
    output logic        memtoreg,
    output logic        alusrc,
    output logic [1:0]  aluop,
    output logic        halted,
    output logic        err_timeout,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        StFetch  = 3'b000,
        StDecode = 3'b001,
        StExec   = 3'b010,
        StMem    = 3'b011,
        StWb     = 3'b100,
        StUnused = 3'b101,
        StPcupd  = 3'b110,
        StHalt   = 3'b111
    } state_e;

    typedef enum logic [2:0] {
        ClsR, ClsI, ClsLw, ClsSw, ClsBeq, ClsBne
    } class_e;

    // Last wait count before giving up: reaching it with mem_ready still low ends the phase.
    localparam logic [7:0] WaitLast = 8'(WAIT_MAX - 1);

    state_e      state_q;
    class_e      class_q;
    logic        taken_q;
    logic [7:0]  wait_q;
    logic        err_q;
    logic [31:0] instret_q;

    class_e      dec_class;
    logic        dec_legal;

    always_comb begin
        dec_class = ClsR;
        dec_legal = 1'b1;
        case (opcode)
            7'b0110011: dec_class = ClsR;
            7'b0010011: dec_class = ClsI;
            7'b0000011: dec_class = ClsLw;
            7'b0100011: dec_class = ClsSw;
            7'b1100011: begin
                if (funct3 == 3'b000)      dec_class = ClsBeq;
                else if (funct3 == 3'b001) dec_class = ClsBne;
                else                       dec_legal = 1'b0;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            class_q   <= ClsR;
            taken_q   <= 1'b0;
            wait_q    <= '0;
            err_q     <= 1'b0;
            instret_q <= '0;
        end else begin
            // Counter is zero on entry to every state; only the wait branches keep it counting.
            wait_q <= '0;
            case (state_q)
                StFetch, StMem: begin
                    if (mem_ready) begin
                        if (state_q == StFetch)     state_q <= StDecode;
                        else if (class_q == ClsLw)  state_q <= StWb;
                        else                        state_q <= StPcupd;
                    end else if (wait_q == WaitLast) begin
                        state_q <= StHalt;
                        err_q   <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                StDecode: begin
                    class_q <= dec_class;
                    state_q <= dec_legal ? StExec : StHalt;
                end
                StExec: begin
                    // taken = zero XOR (funct3 == 001); cleared for non-branches.
                    taken_q <= (class_q == ClsBeq) ? zero :
                               (class_q == ClsBne) ? ~zero : 1'b0;
                    case (class_q)
                        ClsR, ClsI:   state_q <= StWb;
                        ClsLw, ClsSw: state_q <= StMem;
                        default:      state_q <= StPcupd;
                    endcase
                end
                StWb: state_q <= StPcupd;
                StPcupd: begin
                    instret_q <= instret_q + 32'd1;
                    state_q   <= StFetch;
                end
                StHalt:  state_q <= StHalt;
                default: state_q <= StHalt;
            endcase
        end
    end

    // Strobes depend only on registered state and class (ir_load also qualifies on mem_ready).
    always_comb begin
        ir_load  = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        memtoreg = 1'b0;
        alusrc   = 1'b0;
        aluop    = 2'b00;
        pcsrc    = 1'b0;
        halted   = 1'b0;
        case (state_q)
            StFetch: begin
                memread = 1'b1;
                ir_load = mem_ready;
            end
            StExec: begin
                case (class_q)
                    ClsR:         aluop = 2'b10;
                    ClsI: begin
                        aluop  = 2'b10;
                        alusrc = 1'b1;
                    end
                    ClsLw, ClsSw: alusrc = 1'b1;
                    default:      aluop = 2'b01;
                endcase
            end
            StMem: begin
                memread  = (class_q == ClsLw);
                memwrite = (class_q == ClsSw);
            end
            StWb: begin
                regwrite = 1'b1;
                memtoreg = (class_q == ClsLw);
            end
            StPcupd: pcsrc  = taken_q;
            StHalt:  halted = 1'b1;
            default: ;
        endcase
    end

    assign estado      = state_q;
    assign err_timeout = err_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_unidade_controle.sv
module tb_unidade_controle;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        zero;
    logic        mem_ready;
    logic [2:0]  estado;
    logic        pcsrc, ir_load, memread, memwrite, regwrite, memtoreg, alusrc;
    logic [1:0]  aluop;
    logic        halted, err_timeout;
    logic [31:0] instret;

    int n_chk = 0;
    int n_err = 0;

    unidade_controle #(.WAIT_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .estado(estado), .pcsrc(pcsrc), .ir_load(ir_load),
        .memread(memread), .memwrite(memwrite), .regwrite(regwrite), .memtoreg(memtoreg),
        .alusrc(alusrc), .aluop(aluop), .halted(halted), .err_timeout(err_timeout),
        .instret(instret)
    );

    always #5 clk = ~clk;

    // {estado, ir_load, memread, memwrite, regwrite, memtoreg, alusrc, aluop, pcsrc, halted}
    logic [12:0] obs;
    assign obs = {estado, ir_load, memread, memwrite, regwrite, memtoreg, alusrc, aluop,
                  pcsrc, halted};

    localparam logic [12:0] FETCH_RDY  = 13'b000_110000_00_0_0;
    localparam logic [12:0] FETCH_WAIT = 13'b000_010000_00_0_0;
    localparam logic [12:0] DEC        = 13'b001_000000_00_0_0;
    localparam logic [12:0] EX_R       = 13'b010_000000_10_0_0;
    localparam logic [12:0] EX_I       = 13'b010_000001_10_0_0;
    localparam logic [12:0] EX_MEM     = 13'b010_000001_00_0_0;
    localparam logic [12:0] EX_BR      = 13'b010_000000_01_0_0;
    localparam logic [12:0] MEM_RD     = 13'b011_010000_00_0_0;
    localparam logic [12:0] MEM_WR     = 13'b011_001000_00_0_0;
    localparam logic [12:0] WB_ALU     = 13'b100_000100_00_0_0;
    localparam logic [12:0] WB_LD      = 13'b100_000110_00_0_0;
    localparam logic [12:0] PC_N       = 13'b110_000000_00_0_0;
    localparam logic [12:0] PC_T       = 13'b110_000000_00_1_0;
    localparam logic [12:0] HALTED     = 13'b111_000000_00_0_1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; opcode = '0; funct3 = '0; zero = 1'b0; mem_ready = 1'b0;
        #2;
        n_chk++;
        if (obs !== FETCH_WAIT || instret !== 32'd0 || err_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: obs=%b instret=%0d err=%b exp=%b 0 0",
                     obs, instret, err_timeout, FETCH_WAIT);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rtype();
        logic [12:0] exp [6] = '{FETCH_RDY, DEC, EX_R, WB_ALU, PC_N, FETCH_RDY};
        opcode = 7'b0110011; funct3 = 3'b000; mem_ready = 1'b1;
        n_chk++;
        if (instret !== 32'd0) begin
            n_err++; $display("FAIL r_instret_before: got=%0d exp=0", instret);
        end
        for (int i = 0; i < 6; i++) begin
            #1;
            n_chk++;
            if (obs !== exp[i]) begin
                n_err++; $display("FAIL r_seq[%0d]: got=%b exp=%b", i, obs, exp[i]);
            end
            if (i < 5) step();
        end
        n_chk++;
        if (instret !== 32'd1) begin
            n_err++; $display("FAIL r_instret_after: got=%0d exp=1", instret);
        end
    endtask

    task automatic test_branch();
        logic [12:0] exp_beq [5] = '{FETCH_RDY, DEC, EX_BR, PC_T, FETCH_RDY};
        logic [12:0] exp_bne [5] = '{FETCH_RDY, DEC, EX_BR, PC_N, FETCH_RDY};
        opcode = 7'b1100011; funct3 = 3'b000; zero = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_chk++;
            if (obs !== exp_beq[i]) begin
                n_err++; $display("FAIL beq_seq[%0d]: got=%b exp=%b", i, obs, exp_beq[i]);
            end
            if (i < 4) step();
        end
        funct3 = 3'b001;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_chk++;
            if (obs !== exp_bne[i]) begin
                n_err++; $display("FAIL bne_seq[%0d]: got=%b exp=%b", i, obs, exp_bne[i]);
            end
            if (i < 4) step();
        end
        zero = 1'b0;
        n_chk++;
        if (instret !== 32'd3) begin
            n_err++; $display("FAIL branch_instret: got=%0d exp=3", instret);
        end
    endtask

    task automatic test_load_wait();
        logic        mr  [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [12:0] exp [10] = '{FETCH_RDY, DEC, EX_MEM, MEM_RD, MEM_RD, MEM_RD, MEM_RD,
                                  WB_LD, PC_N, FETCH_RDY};
        opcode = 7'b0000011; funct3 = 3'b010;
        for (int i = 0; i < 10; i++) begin
            mem_ready = mr[i];
            #1;
            n_chk++;
            if (obs !== exp[i]) begin
                n_err++; $display("FAIL lw_seq[%0d]: got=%b exp=%b", i, obs, exp[i]);
            end
            if (i < 9) step();
        end
        n_chk++;
        if (instret !== 32'd4) begin
            n_err++; $display("FAIL lw_instret: got=%0d exp=4", instret);
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] exp_i  [6] = '{FETCH_RDY, DEC, EX_I, WB_ALU, PC_N, FETCH_RDY};
        logic [12:0] exp_sw [6] = '{FETCH_RDY, DEC, EX_MEM, MEM_WR, PC_N, FETCH_RDY};
        mem_ready = 1'b1;
        opcode = 7'b0010011; funct3 = 3'b000;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_chk++;
            if (obs !== exp_i[i]) begin
                n_err++; $display("FAIL i_seq[%0d]: got=%b exp=%b", i, obs, exp_i[i]);
            end
            if (i < 5) step();
        end
        opcode = 7'b0100011; funct3 = 3'b010;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_chk++;
            if (obs !== exp_sw[i]) begin
                n_err++; $display("FAIL sw_seq[%0d]: got=%b exp=%b", i, obs, exp_sw[i]);
            end
            if (i < 5) step();
        end
        n_chk++;
        if (instret !== 32'd6) begin
            n_err++; $display("FAIL b2b_instret: got=%0d exp=6", instret);
        end
    endtask

    task automatic test_illegal();
        logic [12:0] exp [6] = '{FETCH_RDY, DEC, HALTED, HALTED, HALTED, HALTED};
        opcode = 7'b1111111; funct3 = 3'b000; mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_chk++;
            if (obs !== exp[i]) begin
                n_err++; $display("FAIL illegal_seq[%0d]: got=%b exp=%b", i, obs, exp[i]);
            end
            if (i < 5) step();
        end
        n_chk++;
        if (err_timeout !== 1'b0 || instret !== 32'd6) begin
            n_err++;
            $display("FAIL illegal_flags: err=%b instret=%0d exp err=0 instret=6",
                     err_timeout, instret);
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (obs !== FETCH_RDY || instret !== 32'd0) begin
            n_err++;
            $display("FAIL illegal_reset: got=%b instret=%0d exp=%b 0", obs, instret, FETCH_RDY);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_sw();
        logic        mr  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [12:0] exp [5] = '{FETCH_RDY, DEC, EX_MEM, MEM_WR, MEM_WR};
        opcode = 7'b0100011; funct3 = 3'b010;
        for (int i = 0; i < 5; i++) begin
            mem_ready = mr[i];
            #1;
            n_chk++;
            if (obs !== exp[i]) begin
                n_err++; $display("FAIL swrst_seq[%0d]: got=%b exp=%b", i, obs, exp[i]);
            end
            if (i < 4) step();
        end
        // Asynchronous: no clock edge between assertion and the check.
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (obs !== FETCH_WAIT || instret !== 32'd0) begin
            n_err++;
            $display("FAIL swrst_async: got=%b instret=%0d exp=%b 0", obs, instret, FETCH_WAIT);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        step();
        n_chk++;
        if (estado !== 3'b001 || instret !== 32'd0) begin
            n_err++;
            $display("FAIL swrst_resume: estado=%b instret=%0d exp 001 0", estado, instret);
        end
    endtask

    task automatic test_timeout();
        rst_n = 1'b0; mem_ready = 1'b0; opcode = 7'b0110011;
        @(negedge clk);
        rst_n = 1'b1;
        // With WAIT_MAX=15, FETCH lasts 15 wait cycles, then HALT.
        for (int i = 0; i < 15; i++) begin
            #1;
            n_chk++;
            if (obs !== FETCH_WAIT) begin
                n_err++; $display("FAIL timeout_wait[%0d]: got=%b exp=%b", i, obs, FETCH_WAIT);
            end
            @(posedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            #1;
            n_chk++;
            if (obs !== HALTED || err_timeout !== 1'b1) begin
                n_err++;
                $display("FAIL timeout_halt[%0d]: got=%b err=%b exp=%b 1",
                         i, obs, err_timeout, HALTED);
            end
            mem_ready = 1'b1;
            @(posedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (obs !== FETCH_RDY || err_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_reset: got=%b err=%b exp=%b 0", obs, err_timeout, FETCH_RDY);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_branch();
        test_load_wait();
        test_back_to_back();
        test_illegal();
        test_reset_mid_sw();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 Parameter WAIT_MAX, default 15, SHALL be the maximum number of cycles to wait for mem_ready in one memory phase (range 1..255).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 opcode  input  7  SHALL be instruction bits [6:0] from the external instruction register.
REQ-005 funct3  input  3  SHALL be instruction bits [14:12].
REQ-006 zero  input  1  SHALL be the ALU zero flag, sampled in EXEC only.
REQ-007 mem_ready  input  1  SHALL indicate memory completion in FETCH/MEM.
REQ-008 estado  output  3  SHALL be the registered state code driven to the PC-update and datapath blocks.
REQ-009 pcsrc  output  1  SHALL select branch target (1) or PC+1 (0); meaningful only when estado=110.
REQ-010 ir_load, memread, memwrite, regwrite, memtoreg, alusrc  output  1 each  SHALL be datapath strobes per REQ-013..REQ-019.
REQ-011 aluop  output  2  SHALL be 00 add, 01 subtract, 10 funct-decoded.
REQ-012 halted  output  1; err_timeout  output  1; instret  output  32 (retired-instruction count).

Function
REQ-013 States: FETCH 000, DECODE 001, EXEC 010, MEM 011, WB 100, PCUPD 110, HALT 111; code 101 unused, SHALL transition to HALT if ever reached.
REQ-014 FETCH: memread=1; on mem_ready=1 -> ir_load=1 for that cycle, next DECODE; else stay, incrementing wait counter.
REQ-015 DECODE: latch opcode/funct3 into internal class register; legal opcodes 0110011 (R), 0010011 (I), 0000011 (LW), 0100011 (SW), 1100011 with funct3 000/001 (BEQ/BNE) -> EXEC; any other -> HALT.
REQ-016 EXEC: R -> aluop=10, alusrc=0; I -> aluop=10, alusrc=1; LW/SW -> aluop=00, alusrc=1; branch -> aluop=01, alusrc=0, latch taken = zero XOR (funct3==001). Next: R/I -> WB; LW/SW -> MEM; branch -> PCUPD.
REQ-017 MEM: LW memread=1, SW memwrite=1, held until mem_ready=1; then LW -> WB, SW -> PCUPD.
REQ-018 WB: regwrite=1 exactly one cycle; memtoreg=1 for LW, else 0; next PCUPD.
REQ-019 PCUPD: pcsrc=taken register (0 for non-branches); instret increments by 1 (32-bit wrap 0xFFFFFFFF->0); next FETCH.
REQ-020 Strobes SHALL be decoded only from registered estado and latched class; all are 0 in states not listed for them.
REQ-021 Wait counter SHALL clear on every state entry; if mem_ready is still 0 after WAIT_MAX consecutive wait cycles in FETCH or MEM -> HALT with err_timeout=1.
REQ-022 mem_ready asserted in any state other than FETCH/MEM SHALL be ignored.
REQ-023 HALT: halted=1, all strobes 0, estado=111, no exit except reset; err_timeout sticky.
REQ-024 Latencies with mem_ready immediate: R/I 5 cycles, LW 6, SW 5, branch 4.

Reset
REQ-025 rst_n=0 SHALL immediately force estado=000, taken=0, wait counter=0, instret=0, halted=0, err_timeout=0, all strobes 0 except memread=1 (FETCH decode).
REQ-026 Reset asserted mid-instruction SHALL abandon it without incrementing instret; first rising edge after deassertion evaluates FETCH.

Verification
REQ-027 R-type 0110011, mem_ready=1 always -> estado 000,001,010,100,110,000; regwrite high only in 100; pcsrc=0; instret 0->1.
REQ-028 BEQ with zero=1 -> 000,001,010,110; pcsrc=1 at 110; BNE with zero=1 -> pcsrc=0.
REQ-029 LW with mem_ready low 3 cycles in MEM -> MEM held 4 cycles, memread=1 throughout, then WB with memtoreg=1.
REQ-030 mem_ready held 0 in FETCH, WAIT_MAX=15 -> HALT after 15 wait cycles, err_timeout=1, halted=1, stays until rst_n=0.
REQ-031 Opcode 1111111 -> DECODE then HALT, err_timeout=0, instret unchanged.
REQ-032 rst_n pulsed low during MEM of SW -> estado=000 asynchronously, memwrite=0, instret unchanged.
